// File: rtl/aoc2_range_parser.sv
// aoc2_range_parser
//   Front end for the day-2 range summing datapath. Parses an ASCII stream
//   such as "11-22,95-115,...\n" into binary ranges, one per handshake,
//   together with the decimal digit count of each bound.
//
// Ports
//   clock        in   1           clock, all state on posedge
//   reset        in   1           synchronous, active-high
//   byte_in      in   8           ASCII input byte
//   byte_valid   in   1           byte_in valid
//   byte_last    in   1           byte_in is the final byte of the input
//   byte_ready   out  1           parser accepts a byte this cycle
//   lo_out       out  DATA_WIDTH  range lower bound
//   hi_out       out  DATA_WIDTH  range upper bound
//   lo_digs      out  DIG_W       decimal digits of lo_out
//   hi_digs      out  DIG_W       decimal digits of hi_out
//   range_valid  out  1           range outputs valid
//   range_ready  in   1           downstream accepts the range
//   range_cnt    out  16          ranges emitted since reset (wraps)
//   done         out  1           sticky: final range accepted
//   err          out  1           sticky: malformed input detected
//
// Build option
//   AOC2_RANGE_SPLIT_EN : split ranges that cross a decade so every emitted
//                         range has lo_digs == hi_digs.

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module aoc2_range_parser #(
   parameter  int unsigned DATA_WIDTH = `DATA_WIDTH,
   parameter  int unsigned MAX_DIGS   = 19,
   localparam int unsigned DIG_W      = $clog2(MAX_DIGS + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   input  logic                  byte_last,
   output logic                  byte_ready,
   output logic [DATA_WIDTH-1:0] lo_out,
   output logic [DATA_WIDTH-1:0] hi_out,
   output logic [DIG_W-1:0]      lo_digs,
   output logic [DIG_W-1:0]      hi_digs,
   output logic                  range_valid,
   input  logic                  range_ready,
   output logic [15:0]           range_cnt,
   output logic                  done,
   output logic                  err
);

   localparam logic [2:0] S_LO    = 3'd0;
   localparam logic [2:0] S_HI    = 3'd1;
   localparam logic [2:0] S_EMIT  = 3'd2;
`ifdef AOC2_RANGE_SPLIT_EN
   localparam logic [2:0] S_SPLIT = 3'd3;
`endif
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   function automatic logic [DATA_WIDTH-1:0] mul10(input logic [DATA_WIDTH-1:0] x);
      return (x << 3) + (x << 1);
   endfunction

   logic [2:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0] lo_q, lo_d;
   logic [DATA_WIDTH-1:0] hi_q, hi_d;
   logic [DIG_W-1:0]      digs_q, digs_d;
   logic [DIG_W-1:0]      lo_digs_q, lo_digs_d;
   logic [DIG_W-1:0]      hi_digs_q, hi_digs_d;
   logic                  last_q, last_d;
   logic [15:0]           cnt_q, cnt_d;
`ifdef AOC2_RANGE_SPLIT_EN
   // top_q holds the full upper bound; hi_q is the current sub-range top.
   // p10_q is 10^lo_digs while a range is being emitted.
   logic [DATA_WIDTH-1:0] top_q, top_d;
   logic [DATA_WIDTH-1:0] p10_q, p10_d;
   logic [DATA_WIDTH-1:0] p10_x10;
`endif

   logic                  accept;
   logic                  is_digit, is_ws, is_nl, is_comma, is_dash;
   logic                  digs_full;
   logic [DATA_WIDTH-1:0] acc_next;
   logic [DIG_W-1:0]      digs_inc;
   logic                  do_term;
   logic [DATA_WIDTH-1:0] term_val;
   logic [DIG_W-1:0]      term_digs;

   assign byte_ready  = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_ERR);
   assign accept      = byte_valid && byte_ready;
   assign range_valid = (state_q == S_EMIT);
   assign done        = (state_q == S_DONE);
   assign err         = (state_q == S_ERR);
   assign lo_out      = lo_q;
   assign hi_out      = hi_q;
   assign lo_digs     = lo_digs_q;
   assign hi_digs     = hi_digs_q;
   assign range_cnt   = cnt_q;

   assign is_digit  = (byte_in >= 8'h30) && (byte_in <= 8'h39);
   assign is_ws     = (byte_in == 8'h20) || (byte_in == 8'h0D);
   assign is_nl     = (byte_in == 8'h0A);
   assign is_comma  = (byte_in == 8'h2C);
   assign is_dash   = (byte_in == 8'h2D);
   assign digs_full = (digs_q == DIG_W'(MAX_DIGS));
   // ASCII digits carry their value in the low nibble.
   assign acc_next  = mul10(acc_q) + DATA_WIDTH'(byte_in[3:0]);
   assign digs_inc  = digs_q + DIG_W'(1);
`ifdef AOC2_RANGE_SPLIT_EN
   assign p10_x10   = mul10(p10_q);
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      digs_d    = digs_q;
      lo_digs_d = lo_digs_q;
      hi_digs_d = hi_digs_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
`ifdef AOC2_RANGE_SPLIT_EN
      top_d     = top_q;
      p10_d     = p10_q;
`endif
      do_term   = 1'b0;
      term_val  = acc_q;
      term_digs = digs_q;

      case (state_q)
         S_LO: if (accept) begin
            if (is_digit) begin
               // A lower bound cannot end the stream.
               if (digs_full || byte_last) state_d = S_ERR;
               else begin
                  acc_d  = acc_next;
                  digs_d = digs_inc;
`ifdef AOC2_RANGE_SPLIT_EN
                  p10_d  = mul10(p10_q);
`endif
               end
            end else if (is_dash) begin
               if (digs_q == '0 || byte_last) state_d = S_ERR;
               else begin
                  lo_d      = acc_q;
                  lo_digs_d = digs_q;
                  acc_d     = '0;
                  digs_d    = '0;
                  state_d   = S_HI;
               end
            end else if ((is_ws || is_nl) && byte_last) begin
               // Trailing whitespace after the final range ends the input.
               state_d = (digs_q == '0) ? S_DONE : S_ERR;
            end else if (!is_ws) begin
               state_d = S_ERR;
            end
         end

         S_HI: if (accept) begin
            if (is_digit) begin
               if (digs_full) state_d = S_ERR;
               else if (byte_last) begin
                  do_term   = 1'b1;
                  term_val  = acc_next;
                  term_digs = digs_inc;
               end else begin
                  acc_d  = acc_next;
                  digs_d = digs_inc;
               end
            end else if (is_comma || is_nl || (is_ws && byte_last)) begin
               if (digs_q == '0) state_d = S_ERR;
               else do_term = 1'b1;
            end else if (!is_ws) begin
               state_d = S_ERR;
            end

            if (do_term) begin
               if (lo_q > term_val) state_d = S_ERR;
               else begin
`ifdef AOC2_RANGE_SPLIT_EN
                  top_d     = term_val;
                  hi_d      = (term_val > p10_q - DATA_WIDTH'(1)) ? p10_q - DATA_WIDTH'(1) : term_val;
                  hi_digs_d = lo_digs_q;
`else
                  hi_d      = term_val;
                  hi_digs_d = term_digs;
`endif
                  last_d    = byte_last;
                  acc_d     = '0;
                  digs_d    = '0;
                  state_d   = S_EMIT;
               end
            end
         end

         S_EMIT: if (range_ready) begin
            cnt_d = cnt_q + 16'd1;
`ifdef AOC2_RANGE_SPLIT_EN
            if (hi_q != top_q) state_d = S_SPLIT;
            else begin
               state_d = last_q ? S_DONE : S_LO;
               p10_d   = DATA_WIDTH'(1);
            end
`else
            state_d = last_q ? S_DONE : S_LO;
`endif
         end

`ifdef AOC2_RANGE_SPLIT_EN
         S_SPLIT: begin
            lo_d      = p10_q;
            lo_digs_d = lo_digs_q + DIG_W'(1);
            hi_digs_d = lo_digs_q + DIG_W'(1);
            p10_d     = p10_x10;
            hi_d      = (top_q > p10_x10 - DATA_WIDTH'(1)) ? p10_x10 - DATA_WIDTH'(1) : top_q;
            state_d   = S_EMIT;
         end
`endif

         S_DONE: state_d = S_DONE;
         S_ERR:  state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_LO;
         acc_q     <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         digs_q    <= '0;
         lo_digs_q <= '0;
         hi_digs_q <= '0;
         last_q    <= 1'b0;
         cnt_q     <= '0;
`ifdef AOC2_RANGE_SPLIT_EN
         top_q     <= '0;
         p10_q     <= DATA_WIDTH'(1);
`endif
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         digs_q    <= digs_d;
         lo_digs_q <= lo_digs_d;
         hi_digs_q <= hi_digs_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
`ifdef AOC2_RANGE_SPLIT_EN
         top_q     <= top_d;
         p10_q     <= p10_d;
`endif
      end
   end

endmodule

// File: tb/tb_aoc2_range_parser.sv
// tb_aoc2_range_parser
//   Directed bench for aoc2_range_parser: byte stream in, ranges out.
//   Expected ranges are hand-computed; AOC2_RANGE_SPLIT_EN selects the
//   split-range expectations.

module tb_aoc2_range_parser;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_last = 1'b0;
   logic        byte_ready;
   logic [63:0] lo_out, hi_out;
   logic [4:0]  lo_digs, hi_digs;
   logic        range_valid;
   logic        range_ready = 1'b0;
   logic [15:0] range_cnt;
   logic        done, err;

   int unsigned checks = 0;
   int unsigned errors = 0;

   aoc2_range_parser #(.DATA_WIDTH(64), .MAX_DIGS(19)) dut (
      .clock       (clock),
      .reset       (reset),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .byte_last   (byte_last),
      .byte_ready  (byte_ready),
      .lo_out      (lo_out),
      .hi_out      (hi_out),
      .lo_digs     (lo_digs),
      .hi_digs     (hi_digs),
      .range_valid (range_valid),
      .range_ready (range_ready),
      .range_cnt   (range_cnt),
      .done        (done),
      .err         (err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      byte_valid  = 1'b0;
      range_ready = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Present one byte at a negedge and hold it until the parser takes it.
   task automatic send(input logic [7:0] b, input logic last);
      int n = 0;
      byte_in    = b;
      byte_last  = last;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!byte_ready) chk("send_timeout", 64'd0, 64'd1);
      @(posedge clock);
      @(negedge clock);
      byte_valid = 1'b0;
      byte_last  = 1'b0;
   endtask

   task automatic send_str(input string s, input logic last_at_end);
      for (int i = 0; i < s.len(); i++)
         send(s[i], last_at_end && (i == s.len() - 1));
   endtask

   task automatic expect_range(input string tag, input logic [63:0] lo, input logic [63:0] hi,
                               input logic [4:0] ld, input logic [4:0] hd);
      int n = 0;
      while (!range_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_valid"}, 64'(range_valid), 64'd1);
      chk({tag, "_lo"}, lo_out, lo);
      chk({tag, "_hi"}, hi_out, hi);
      chk({tag, "_lodigs"}, 64'(lo_digs), 64'(ld));
      chk({tag, "_hidigs"}, 64'(hi_digs), 64'(hd));
      range_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      range_ready = 1'b0;
   endtask

   initial begin
      // Reset values
      do_reset();
      chk("rst_byte_ready", 64'(byte_ready), 64'd1);
      chk("rst_range_valid", 64'(range_valid), 64'd0);
      chk("rst_lo", lo_out, 64'd0);
      chk("rst_hi", hi_out, 64'd0);
      chk("rst_digs", 64'({lo_digs, hi_digs}), 64'd0);
      chk("rst_cnt", 64'(range_cnt), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);

      // Two ranges, second ended by a final newline
      send_str("11-22,", 1'b0);
      chk("t1_latency", 64'(range_valid), 64'd1);
      chk("t1_busy", 64'(byte_ready), 64'd0);
      expect_range("t1a", 64'd11, 64'd22, 5'd2, 5'd2);
      send_str("33-44\n", 1'b1);
      expect_range("t1b", 64'd33, 64'd44, 5'd2, 5'd2);
      chk("t1_cnt", 64'(range_cnt), 64'd2);
      chk("t1_done", 64'(done), 64'd1);
      chk("t1_ready_done", 64'(byte_ready), 64'd0);
      chk("t1_valid_done", 64'(range_valid), 64'd0);
      chk("t1_err", 64'(err), 64'd0);

      // Range crossing a decade
      do_reset();
      send_str("95-115\n", 1'b1);
`ifdef AOC2_RANGE_SPLIT_EN
      expect_range("t2a", 64'd95, 64'd99, 5'd2, 5'd2);
      chk("t2_not_done", 64'(done), 64'd0);
      expect_range("t2b", 64'd100, 64'd115, 5'd3, 5'd3);
      chk("t2_cnt", 64'(range_cnt), 64'd2);
`else
      expect_range("t2", 64'd95, 64'd115, 5'd2, 5'd3);
      chk("t2_cnt", 64'(range_cnt), 64'd1);
`endif
      chk("t2_done", 64'(done), 64'd1);

      // Downstream stall, then byte handed over right after the handshake
      do_reset();
      send_str("11-22,", 1'b0);
      for (int c = 0; c < 5; c++) begin
         chk("t3_stall_valid", 64'(range_valid), 64'd1);
         chk("t3_stall_lo", lo_out, 64'd11);
         chk("t3_stall_hi", hi_out, 64'd22);
         chk("t3_stall_digs", 64'({lo_digs, hi_digs}), 64'({5'd2, 5'd2}));
         chk("t3_stall_ready", 64'(byte_ready), 64'd0);
         @(negedge clock);
      end
      byte_in     = "3";
      byte_last   = 1'b0;
      byte_valid  = 1'b1;
      range_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      range_ready = 1'b0;
      chk("t3_after_valid", 64'(range_valid), 64'd0);
      chk("t3_after_ready", 64'(byte_ready), 64'd1);
      chk("t3_after_cnt", 64'(range_cnt), 64'd1);
      @(posedge clock);
      @(negedge clock);
      byte_valid = 1'b0;
      send_str("3-44\n", 1'b1);
      expect_range("t3", 64'd33, 64'd44, 5'd2, 5'd2);
      chk("t3_cnt", 64'(range_cnt), 64'd2);

      // Malformed inputs
      do_reset();
      send_str("12,", 1'b0);
      chk("t4a_err", 64'(err), 64'd1);
      chk("t4a_ready", 64'(byte_ready), 64'd1);
      send("5", 1'b0);
      chk("t4a_drain_err", 64'(err), 64'd1);
      chk("t4a_valid", 64'(range_valid), 64'd0);

      do_reset();
      send_str("5-3,", 1'b0);
      chk("t4b_err", 64'(err), 64'd1);
      chk("t4b_valid", 64'(range_valid), 64'd0);
      chk("t4b_cnt", 64'(range_cnt), 64'd0);

      do_reset();
      send_str("1-2-", 1'b0);
      chk("t4c_err", 64'(err), 64'd1);
      send("3", 1'b0);
      chk("t4c_valid", 64'(range_valid), 64'd0);
      chk("t4c_ready", 64'(byte_ready), 64'd1);

      do_reset();
      send_str("1111111111111111111", 1'b0);
      chk("t4d_19_ok", 64'(err), 64'd0);
      send("1", 1'b0);
      chk("t4d_20_err", 64'(err), 64'd1);
      chk("t4d_done", 64'(done), 64'd0);

      // Reset mid-range discards the partial range
      do_reset();
      send_str("123-4", 1'b0);
      do_reset();
      send_str("7-8\n", 1'b1);
      expect_range("t5", 64'd7, 64'd8, 5'd1, 5'd1);
      chk("t5_cnt", 64'(range_cnt), 64'd1);
      chk("t5_done", 64'(done), 64'd1);

      // Largest legal operands
      do_reset();
      send_str("9999999999999999999-9999999999999999999\n", 1'b1);
      expect_range("t6", 64'd9999999999999999999, 64'd9999999999999999999, 5'd19, 5'd19);
      chk("t6_err", 64'(err), 64'd0);
      chk("t6_done", 64'(done), 64'd1);

      // Lone trailing newline after the last range
      do_reset();
      send_str("1-2,", 1'b0);
      expect_range("t7", 64'd1, 64'd2, 5'd1, 5'd1);
      chk("t7_not_done", 64'(done), 64'd0);
      send(8'h0A, 1'b1);
      chk("t7_done", 64'(done), 64'd1);
      chk("t7_err", 64'(err), 64'd0);
      chk("t7_cnt", 64'(range_cnt), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
